serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial W-bit adder stage that drives a 1-bit full-adder cell LSB-first for W cycles.
//  It holds the carry in a flip-flop between bits and assembles the W-bit sum.
//  Operands arrive over a valid/ready handshake from the matrix-datapath sequencer.
//  The result leaves over a valid/ready handshake to the pseudoinverse accumulation stage.
//  An accumulate mode reuses the previous result as operand A, for running dot-product sums.
// PARAMETERS
//  W     16              operand/result width in bits; legal range W >= 2
//  CNTW  $clog2(W)       bit-counter width; derived, do not override
// PORTS
//  CLK        in   1   clock, all state updates on rising edge
//  RST        in   1   asynchronous, active-high reset
//  IN_VALID   in   1   operand word valid
//  IN_READY   out  1   block accepts operands; high only in IDLE
//  A          in   W   operand A, two's complement; ignored when ACC=1
//  B          in   W   operand B, two's complement
//  CIN        in   1   carry into bit 0
//  ACC        in   1   1: operand A := current D register (accumulate)
//  OUT_VALID  out  1   result valid; high only in DONE
//  OUT_READY  in   1   downstream accepts result
//  D          out  W   sum, registered, stable while OUT_VALID=1
//  COUT       out  1   carry out of bit W-1
//  OVF        out  1   signed overflow = carry into bit W-1 XOR COUT
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, D=0, COUT=0, OVF=0, carry FF=0, cnt=0, OUT_VALID=0.
//   IN_READY=1 from the first edge after RST deasserts. A reset mid-operation discards the
//   partial result; no OUT_VALID is produced for it.
//  FSM states: IDLE, SHIFT, DONE. IN_READY=(state==IDLE); OUT_VALID=(state==DONE); both decoded from state.
//  IDLE: on IN_VALID&IN_READY, load the operand registers and go to SHIFT.
//   opA<=ACC?D:A; opB<=B; carry<=CIN; cnt<=0.
//  SHIFT: each cycle, fa(opA[0],opB[0],carry) -> {s,c}.
//   sum_sr <= {s, sum_sr[W-1:1]}; opA,opB shift right by 1; carry<=c; cnt<=cnt+1.
//   When cnt==W-2, latch carry as cmsb (carry into the MSB).
//   When cnt==W-1, D<={s,sum_sr[W-1:1]}, COUT<=c, OVF<=cmsb^c, and go to DONE.
//  DONE: hold D/COUT/OVF. On OUT_READY go to IDLE.
//   IN_VALID is not accepted in DONE; no bypass path.
//  Latency: handshake edge to OUT_VALID high = W+1 cycles. Minimum issue interval = W+2 cycles.
//  Arithmetic is modulo 2^W; D wraps silently. COUT/OVF flag unsigned/signed overflow.
//  D/COUT/OVF change only on the SHIFT->DONE edge or reset; they persist through IDLE.
//   ACC therefore uses the last delivered sum.
//  ACC=1 right after reset gives D = 0 + B + CIN.
//  IN_VALID held high in DONE/SHIFT has no effect; the transaction is taken in the next IDLE cycle.
//  OUT_READY high outside DONE is ignored.
// STRUCTURE
//  Shared package pinv_pkg holds:
//   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} sadd_state_t;
//   localparam PINV_W = 16 (system default width).
//  One sub-module: full_adder_cell (A, B, Cin -> S, Cout), purely combinational, instantiated once.
//  Everything else stays in this file: FSM, counter, shift registers.
// TESTING (W=16)
//  1. A=0x1234, B=0x4321, CIN=0 -> D=0x5555, COUT=0, OVF=0.
//     OUT_VALID rises exactly 17 cycles after the handshake edge.
//  2. A=0xFFFF, B=0x0001, CIN=0 -> D=0x0000, COUT=1, OVF=0.
//     A=0x0000, B=0x0000, CIN=1 -> D=0x0001.
//  3. A=0x7FFF, B=0x0001 -> D=0x8000, COUT=0, OVF=1.
//     A=0x8000, B=0x8000 -> D=0x0000, COUT=1, OVF=1.
//  4. Accumulate: after D=0x5555, issue ACC=1, A=0xDEAD (ignored), B=0x0001 -> D=0x5556.
//     Repeat 3x -> 0x5559.
//  5. Backpressure: hold OUT_READY=0 for 5 cycles in DONE -> OUT_VALID, D, COUT, OVF stable, IN_READY=0.
//     OUT_READY=1 -> IDLE next cycle, IN_READY=1.
//  6. Reset mid-op: assert RST 8 cycles into SHIFT -> D=0, OUT_VALID=0 immediately.
//     IN_READY=1 after release; a new add gives the correct result.

Source files
------------

// File: rtl/pinv_pkg.sv
// Shared types and defaults for the pseudoinverse datapath blocks.
package pinv_pkg;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} sadd_state_t;

   localparam int PINV_W = 16;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder used by the bit-serial adder stage.
module full_adder_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic cout_o
);

   assign s_o    = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: one full-adder cell walked LSB-first over W cycles,
// with valid/ready handshakes on both sides and an accumulate mode (A := D).
module serial_adder_ctrl
   import pinv_pkg::*;
#(
   parameter  int W    = PINV_W,
   localparam int CNTW = $clog2(W)
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         CIN,
   input  logic         ACC,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [W-1:0] D,
   output logic         COUT,
   output logic         OVF
);

   localparam logic [CNTW-1:0] CNT_PRE_MSB = CNTW'(W - 2);
   localparam logic [CNTW-1:0] CNT_LAST    = CNTW'(W - 1);

   sadd_state_t     state_q, state_d;
   logic [W-1:0]    op_a_q, op_a_d;
   logic [W-1:0]    op_b_q, op_b_d;
   logic [W-1:0]    sum_sr_q, sum_sr_d;
   logic [W-1:0]    d_q, d_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            cmsb_q, cmsb_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;
   logic            fa_s, fa_c;

   full_adder_cell u_fa (
      .a_i    (op_a_q[0]),
      .b_i    (op_b_q[0]),
      .cin_i  (carry_q),
      .s_o    (fa_s),
      .cout_o (fa_c)
   );

   // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      sum_sr_d = sum_sr_q;
      d_d      = d_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cmsb_d   = cmsb_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         S_IDLE: begin
            if (IN_VALID) begin
               op_a_d  = ACC ? d_q : A;
               op_b_d  = B;
               carry_d = CIN;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sum_sr_d = {fa_s, sum_sr_q[W-1:1]};
            op_a_d   = op_a_q >> 1;
            op_b_d   = op_b_q >> 1;
            carry_d  = fa_c;
            cnt_d    = cnt_q + CNTW'(1);
            // The carry leaving bit W-2 is the carry into the sign bit.
            if (cnt_q == CNT_PRE_MSB) cmsb_d = fa_c;
            if (cnt_q == CNT_LAST) begin
               d_d     = sum_sr_d;
               cout_d  = fa_c;
               ovf_d   = cmsb_q ^ fa_c;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (OUT_READY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         sum_sr_q <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cmsb_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         sum_sr_q <= sum_sr_d;
         d_q      <= d_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cmsb_q   <= cmsb_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign IN_READY  = (state_q == S_IDLE);
   assign OUT_VALID = (state_q == S_DONE);
   assign D         = d_q;
   assign COUT      = cout_q;
   assign OVF       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at W=16: vector table plus
// backpressure and mid-operation reset sequences, scoreboard-checked.
module tb_serial_adder_ctrl;

   localparam int W = 16;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         IN_VALID = 1'b0;
   logic         IN_READY;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         CIN = 1'b0;
   logic         ACC = 1'b0;
   logic         OUT_VALID;
   logic         OUT_READY = 1'b0;
   logic [W-1:0] D;
   logic         COUT;
   logic         OVF;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [W-1:0] d;
      logic         cout;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         acc;
      exp_t         e;
   } vec_t;

   exp_t exp_q[$];

   serial_adder_ctrl #(.W(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .A         (A),
      .B         (B),
      .CIN       (CIN),
      .ACC       (ACC),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .D         (D),
      .COUT      (COUT),
      .OVF       (OVF)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running at 1 ms, required to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Issues one operation, checks latency and result, holds OUT_READY low for
   // 'hold' extra DONE cycles, then releases it and checks the return to IDLE.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic acc, input exp_t e, input int hold);
      int   waitn;
      int   lat;
      exp_t got;
      waitn = 0;
      while (!IN_READY && waitn < 50) begin
         tick();
         waitn++;
      end
      check("in_ready_before_issue", 32'(IN_READY), 32'd1);
      A = a; B = b; CIN = cin; ACC = acc; IN_VALID = 1'b1;
      exp_q.push_back(e);
      tick();
      IN_VALID = 1'b0;
      A = W'($urandom); B = W'($urandom); CIN = 1'($urandom); ACC = 1'($urandom);
      // The handshake edge itself counts as cycle 1.
      lat = 1;
      while (!OUT_VALID && lat < 100) begin
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'd17);
      got = exp_q.pop_front();
      check("d", 32'(D), 32'(got.d));
      check("cout", 32'(COUT), 32'(got.cout));
      check("ovf", 32'(OVF), 32'(got.ovf));
      check("in_ready_in_done", 32'(IN_READY), 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_out_valid", 32'(OUT_VALID), 32'd1);
         check("hold_d", 32'(D), 32'(got.d));
         check("hold_cout", 32'(COUT), 32'(got.cout));
         check("hold_ovf", 32'(OVF), 32'(got.ovf));
         check("hold_in_ready", 32'(IN_READY), 32'd0);
      end
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      check("out_valid_after_ready", 32'(OUT_VALID), 32'd0);
      check("in_ready_after_ready", 32'(IN_READY), 32'd1);
      check("d_persists_idle", 32'(D), 32'(got.d));
   endtask

   vec_t vecs[$];

   initial begin
      exp_t e;

      // ACC=1 straight after reset accumulates onto D=0; later ACC rows chain on 0x5555.
      vecs.push_back('{16'hBEEF, 16'h0042, 1'b1, 1'b1, '{16'h0043, 1'b0, 1'b0}});
      vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}});
      vecs.push_back('{16'hDEAD, 16'h0001, 1'b0, 1'b1, '{16'h5556, 1'b0, 1'b0}});
      vecs.push_back('{16'hDEAD, 16'h0001, 1'b0, 1'b1, '{16'h5557, 1'b0, 1'b0}});
      vecs.push_back('{16'hDEAD, 16'h0001, 1'b0, 1'b1, '{16'h5558, 1'b0, 1'b0}});
      vecs.push_back('{16'hDEAD, 16'h0001, 1'b0, 1'b1, '{16'h5559, 1'b0, 1'b0}});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}});
      vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, '{16'h0001, 1'b0, 1'b0}});
      vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}});
      vecs.push_back('{16'h8000, 16'hFFFF, 1'b0, 1'b0, '{16'h7FFF, 1'b1, 1'b1}});

      // Reset values while RST is held.
      repeat (3) @(posedge CLK);
      #1;
      check("rst_d", 32'(D), 32'd0);
      check("rst_cout", 32'(COUT), 32'd0);
      check("rst_ovf", 32'(OVF), 32'd0);
      check("rst_out_valid", 32'(OUT_VALID), 32'd0);
      RST = 1'b0;
      tick();
      check("rst_in_ready", 32'(IN_READY), 32'd1);

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].acc, vecs[i].e, 0);

      // Backpressure: result held for 5 cycles in DONE.
      e = '{16'h0003, 1'b0, 1'b0};
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0, e, 5);

      // Reset 8 cycles into SHIFT discards the partial result.
      A = 16'h1111; B = 16'h2222; CIN = 1'b0; ACC = 1'b0; IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      repeat (8) tick();
      check("midop_busy", 32'(IN_READY), 32'd0);
      RST = 1'b1;
      #1;
      check("midop_rst_d", 32'(D), 32'd0);
      check("midop_rst_out_valid", 32'(OUT_VALID), 32'd0);
      check("midop_rst_cout", 32'(COUT), 32'd0);
      tick();
      RST = 1'b0;
      tick();
      check("midop_in_ready", 32'(IN_READY), 32'd1);
      check("midop_no_out_valid", 32'(OUT_VALID), 32'd0);
      e = '{16'h1000, 1'b0, 1'b0};
      run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, e, 0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
